// File: rtl/hit_dispatch_sched_pkg.sv
// Shared definitions for the hit extraction / dispatch slice: lane geometry,
// scheduler state encoding and nucleotide codes.
package hit_dispatch_sched_pkg;

    localparam int NUM_LANES_DEF = 22;
    localparam int ADDR_W_DEF    = 8;
    localparam int LANE_W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        NT_A = 2'd0,
        NT_G = 2'd1,
        NT_T = 2'd2,
        NT_C = 2'd3
    } nucleotide_e;

endpackage

// File: rtl/hit_prio_enc.sv
// Lowest-index-first priority encoder over a lane mask: found flag, binary
// lane index and the one-hot bit to clear. Purely combinational.
module hit_prio_enc
    import hit_dispatch_sched_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int LANE_W    = LANE_W_DEF
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic                 found,
    output logic [LANE_W-1:0]    idx,
    output logic [NUM_LANES-1:0] onehot
);

    // Scan from the top down so the lowest set lane is the last one written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found  = 1'b1;
                idx    = LANE_W'(i);
                onehot = NUM_LANES'(1) << i;
            end
        end
    end

endmodule

// File: rtl/hit_dispatch_sched.sv
// Captures one batch of parallel hits and drains it one hit per handshake,
// lowest lane first. Define HIT_DISPATCH_STATS_EN for hit/batch counters.
module hit_dispatch_sched
    import hit_dispatch_sched_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LANE_W    = LANE_W_DEF
) (
    input  logic                        com_clk,
    input  logic                        reset_n,
    input  logic                        batch_valid,
    output logic                        batch_ready,
    input  logic [NUM_LANES-1:0]        batch_mask,
    input  logic [NUM_LANES*ADDR_W-1:0] batch_q_addr,
    input  logic [NUM_LANES*ADDR_W-1:0] batch_s_addr,
    input  logic [NUM_LANES*ADDR_W-1:0] batch_len,
    output logic                        hit_valid,
    input  logic                        hit_ready,
    output logic [ADDR_W-1:0]           hit_q_addr,
    output logic [ADDR_W-1:0]           hit_s_addr,
    output logic [ADDR_W-1:0]           hit_len,
    output logic [LANE_W-1:0]           hit_lane,
    output logic                        hit_last,
    output logic                        busy
`ifdef HIT_DISPATCH_STATS_EN
    ,
    output logic [15:0]                 stat_hits,
    output logic [15:0]                 stat_batches
`endif
);

    sched_state_e state_q, state_d;

    logic [NUM_LANES-1:0]        pending_q, pending_d;
    logic [NUM_LANES*ADDR_W-1:0] sh_q_addr_q, sh_q_addr_d;
    logic [NUM_LANES*ADDR_W-1:0] sh_s_addr_q, sh_s_addr_d;
    logic [NUM_LANES*ADDR_W-1:0] sh_len_q, sh_len_d;

    logic                 hit_valid_q, hit_valid_d;
    logic                 hit_last_q, hit_last_d;
    logic [ADDR_W-1:0]    hit_q_addr_q, hit_q_addr_d;
    logic [ADDR_W-1:0]    hit_s_addr_q, hit_s_addr_d;
    logic [ADDR_W-1:0]    hit_len_q, hit_len_d;
    logic [LANE_W-1:0]    hit_lane_q, hit_lane_d;

    logic                 enc_found;
    logic [LANE_W-1:0]    enc_idx;
    logic [NUM_LANES-1:0] enc_onehot;
    logic [NUM_LANES-1:0] remaining;
    logic                 accept;
    logic                 handshake;
    logic                 load_hit;

    hit_prio_enc #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_prio_enc (
        .mask   (pending_q),
        .found  (enc_found),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign accept    = batch_valid && (state_q == IDLE);
    assign handshake = hit_valid_q && hit_ready;
    assign remaining = pending_q & ~enc_onehot;
    assign load_hit  = (state_q == LOAD) || ((state_q == SEND) && handshake && enc_found);

    // State register.
    always_ff @(posedge com_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (batch_mask != '0)) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (handshake && !enc_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values: capture, lane selection, hit presentation.
    always_comb begin
        pending_d    = pending_q;
        sh_q_addr_d  = sh_q_addr_q;
        sh_s_addr_d  = sh_s_addr_q;
        sh_len_d     = sh_len_q;
        hit_valid_d  = hit_valid_q;
        hit_last_d   = hit_last_q;
        hit_q_addr_d = hit_q_addr_q;
        hit_s_addr_d = hit_s_addr_q;
        hit_len_d    = hit_len_q;
        hit_lane_d   = hit_lane_q;

        if (accept) begin
            pending_d   = batch_mask;
            sh_q_addr_d = batch_q_addr;
            sh_s_addr_d = batch_s_addr;
            sh_len_d    = batch_len;
        end

        if (load_hit) begin
            pending_d    = remaining;
            hit_valid_d  = 1'b1;
            hit_last_d   = (remaining == '0);
            hit_q_addr_d = sh_q_addr_q[enc_idx*ADDR_W +: ADDR_W];
            hit_s_addr_d = sh_s_addr_q[enc_idx*ADDR_W +: ADDR_W];
            hit_len_d    = sh_len_q[enc_idx*ADDR_W +: ADDR_W];
            hit_lane_d   = enc_idx;
        end else if ((state_q == SEND) && handshake) begin
            hit_valid_d = 1'b0;
            hit_last_d  = 1'b0;
        end
    end

    always_ff @(posedge com_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= '0;
            hit_valid_q  <= 1'b0;
            hit_last_q   <= 1'b0;
            hit_q_addr_q <= '0;
            hit_s_addr_q <= '0;
            hit_len_q    <= '0;
            hit_lane_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            hit_valid_q  <= hit_valid_d;
            hit_last_q   <= hit_last_d;
            hit_q_addr_q <= hit_q_addr_d;
            hit_s_addr_q <= hit_s_addr_d;
            hit_len_q    <= hit_len_d;
            hit_lane_q   <= hit_lane_d;
        end
    end

    // NOTE: shadow fields carry no reset; they are only read for lanes set in pending_q, which is reset.
    always_ff @(posedge com_clk) begin
        sh_q_addr_q <= sh_q_addr_d;
        sh_s_addr_q <= sh_s_addr_d;
        sh_len_q    <= sh_len_d;
    end

    assign batch_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign hit_valid   = hit_valid_q;
    assign hit_last    = hit_last_q;
    assign hit_q_addr  = hit_q_addr_q;
    assign hit_s_addr  = hit_s_addr_q;
    assign hit_len     = hit_len_q;
    assign hit_lane    = hit_lane_q;

`ifdef HIT_DISPATCH_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_batches_q, stat_batches_d;

    // Saturating counters: hold at 0xFFFF rather than wrap.
    always_comb begin
        stat_hits_d    = stat_hits_q;
        stat_batches_d = stat_batches_q;
        if (handshake && (stat_hits_q != 16'hFFFF)) begin
            stat_hits_d = stat_hits_q + 16'd1;
        end
        if (accept && (batch_mask != '0) && (stat_batches_q != 16'hFFFF)) begin
            stat_batches_d = stat_batches_q + 16'd1;
        end
    end

    always_ff @(posedge com_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits_q    <= '0;
            stat_batches_q <= '0;
        end else begin
            stat_hits_q    <= stat_hits_d;
            stat_batches_q <= stat_batches_d;
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_batches = stat_batches_q;
`endif

endmodule

// File: tb/tb_hit_dispatch_sched.sv
// Self-checking bench for hit_dispatch_sched: directed and random batches
// checked against a queue-based model of the expected hit stream.
module tb_hit_dispatch_sched;
    import hit_dispatch_sched_pkg::*;

    localparam int NL = NUM_LANES_DEF;
    localparam int AW = ADDR_W_DEF;
    localparam int LW = LANE_W_DEF;

    logic              com_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              batch_valid;
    logic              batch_ready;
    logic [NL-1:0]     batch_mask;
    logic [NL*AW-1:0]  batch_q_addr, batch_s_addr, batch_len;
    logic              hit_valid, hit_ready;
    logic [AW-1:0]     hit_q_addr, hit_s_addr, hit_len;
    logic [LW-1:0]     hit_lane;
    logic              hit_last, busy;
`ifdef HIT_DISPATCH_STATS_EN
    logic [15:0]       stat_hits, stat_batches;
    int                exp_hits = 0;
    int                exp_batches = 0;
`endif

    always #5 com_clk = ~com_clk;

    hit_dispatch_sched dut (
        .com_clk      (com_clk),
        .reset_n      (reset_n),
        .batch_valid  (batch_valid),
        .batch_ready  (batch_ready),
        .batch_mask   (batch_mask),
        .batch_q_addr (batch_q_addr),
        .batch_s_addr (batch_s_addr),
        .batch_len    (batch_len),
        .hit_valid    (hit_valid),
        .hit_ready    (hit_ready),
        .hit_q_addr   (hit_q_addr),
        .hit_s_addr   (hit_s_addr),
        .hit_len      (hit_len),
        .hit_lane     (hit_lane),
        .hit_last     (hit_last),
        .busy         (busy)
`ifdef HIT_DISPATCH_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_batches (stat_batches)
`endif
    );

    typedef struct {
        logic [AW-1:0] q;
        logic [AW-1:0] s;
        logic [AW-1:0] len;
        logic [LW-1:0] lane;
        logic          last;
    } hit_t;

    hit_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [NL-1:0]    cur_mask, nxt_mask;
    logic [NL*AW-1:0] cur_q, cur_s, cur_l;
    logic [NL*AW-1:0] nxt_q, nxt_s, nxt_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_fields(output logic [NL*AW-1:0] q, output logic [NL*AW-1:0] s,
                              output logic [NL*AW-1:0] l);
        for (int j = 0; j < NL; j++) begin
            q[j*AW +: AW] = AW'($urandom_range(0, 255));
            s[j*AW +: AW] = AW'($urandom_range(0, 255));
            l[j*AW +: AW] = AW'($urandom_range(0, 255));
        end
    endtask

    function automatic logic [NL-1:0] gen_mask(input bit nonzero);
        logic [NL-1:0] m;
        int            r;
        r = $urandom_range(0, 5);
        m = NL'($urandom());
        if (r == 0) m = '0;
        if (r == 1) m = NL'(1) << $urandom_range(0, NL - 1);
        if (nonzero && (m == '0)) m = NL'(1) << $urandom_range(0, NL - 1);
        return m;
    endfunction

    // Reference: one hit per set lane in ascending order; last marks the highest set lane.
    task automatic model_batch();
        int   top;
        hit_t h;
        top = -1;
        for (int j = 0; j < NL; j++) if (cur_mask[j]) top = j;
        for (int j = 0; j < NL; j++) begin
            if (cur_mask[j]) begin
                h.q    = cur_q[j*AW +: AW];
                h.s    = cur_s[j*AW +: AW];
                h.len  = cur_l[j*AW +: AW];
                h.lane = LW'(j);
                h.last = (j == top);
                exp_q.push_back(h);
            end
        end
    endtask

    // Entered just after a negedge with the scheduler idle; returns at the negedge after accept.
    task automatic start_batch();
        check("ready_before_accept", batch_ready, 1'b1);
        batch_valid  = 1'b1;
        batch_mask   = cur_mask;
        batch_q_addr = cur_q;
        batch_s_addr = cur_s;
        batch_len    = cur_l;
        model_batch();
`ifdef HIT_DISPATCH_STATS_EN
        if (cur_mask != '0) exp_batches++;
`endif
        @(negedge com_clk);
        batch_valid = 1'b0;
        check("valid_low_after_accept", hit_valid, 1'b0);
        if (cur_mask != '0) begin
            check("busy_after_accept", busy, 1'b1);
            check("ready_low_after_accept", batch_ready, 1'b0);
        end else begin
            check("empty_batch_ready", batch_ready, 1'b1);
            check("empty_batch_busy", busy, 1'b0);
        end
    endtask

    // mode 0: ready always high, 1: toggle 1/0, 2: random. hold keeps the next batch offered.
    task automatic drain(input int mode, input bit hold);
        int   cyc;
        bit   rdy;
        hit_t e;
        cyc = 0;
        while ((exp_q.size() > 0) && (cyc < 400)) begin
            @(negedge com_clk);
            cyc++;
            e = exp_q[0];
            check("hit_valid_during_drain", hit_valid, 1'b1);
            check("hit_q_addr", hit_q_addr, e.q);
            check("hit_s_addr", hit_s_addr, e.s);
            check("hit_len", hit_len, e.len);
            check("hit_lane", hit_lane, e.lane);
            check("hit_last", hit_last, e.last);
            check("ready_low_during_drain", batch_ready, 1'b0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            hit_ready = rdy;
            if (hold) begin
                batch_valid  = 1'b1;
                batch_mask   = nxt_mask;
                batch_q_addr = nxt_q;
                batch_s_addr = nxt_s;
                batch_len    = nxt_l;
            end else begin
                batch_valid  = 1'($urandom_range(0, 1));
                batch_mask   = NL'($urandom());
                gen_fields(batch_q_addr, batch_s_addr, batch_len);
            end
            if (rdy) begin
                void'(exp_q.pop_front());
`ifdef HIT_DISPATCH_STATS_EN
                exp_hits++;
`endif
            end
        end
        check("drain_within_budget", exp_q.size(), 0);
        exp_q.delete();
        @(negedge com_clk);
        if (!hold) batch_valid = 1'b0;
        hit_ready = 1'($urandom_range(0, 1));
        check("valid_low_after_drain", hit_valid, 1'b0);
        check("ready_high_after_drain", batch_ready, 1'b1);
        check("busy_low_after_drain", busy, 1'b0);
    endtask

    initial begin
        batch_valid  = 1'b0;
        batch_mask   = '0;
        batch_q_addr = '0;
        batch_s_addr = '0;
        batch_len    = '0;
        hit_ready    = 1'b0;

        // Reset values.
        repeat (2) @(negedge com_clk);
        check("rst_batch_ready", batch_ready, 1'b1);
        check("rst_hit_valid", hit_valid, 1'b0);
        check("rst_hit_last", hit_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hit_q_addr", hit_q_addr, '0);
        check("rst_hit_lane", hit_lane, '0);
        reset_n = 1'b1;
        @(negedge com_clk);

        // Masks 0x1, 0x0, 0x3: two non-empty batches, three hits.
        cur_mask = NL'(1); gen_fields(cur_q, cur_s, cur_l);
        start_batch(); drain(0, 1'b0);
        cur_mask = '0; gen_fields(cur_q, cur_s, cur_l);
        start_batch();
        cur_mask = NL'(3); gen_fields(cur_q, cur_s, cur_l);
        start_batch(); drain(0, 1'b0);
`ifdef HIT_DISPATCH_STATS_EN
        check("stat_batches_directed", stat_batches, 32'd2);
        check("stat_hits_directed", stat_hits, 32'd3);
`endif

        // Mask 0x5: lane0 q=21, lane2 q=19, back-to-back.
        cur_mask = NL'(5); gen_fields(cur_q, cur_s, cur_l);
        cur_q[0*AW +: AW] = AW'(21);
        cur_q[2*AW +: AW] = AW'(19);
        start_batch(); drain(0, 1'b0);

        // Empty batch.
        cur_mask = '0; gen_fields(cur_q, cur_s, cur_l);
        start_batch();

        // All lanes with hit_ready toggling.
        cur_mask = '1; gen_fields(cur_q, cur_s, cur_l);
        start_batch(); drain(1, 1'b0);

        // batch_valid held through a 0x200001 drain; next batch taken right after.
        cur_mask = NL'(22'h200001); gen_fields(cur_q, cur_s, cur_l);
        nxt_mask = gen_mask(1'b1); gen_fields(nxt_q, nxt_s, nxt_l);
        start_batch(); drain(0, 1'b1);
        cur_mask = nxt_mask; cur_q = nxt_q; cur_s = nxt_s; cur_l = nxt_l;
        start_batch(); drain(2, 1'b0);

        // Random batches and random back-pressure.
        for (int b = 0; b < 30; b++) begin
            cur_mask = gen_mask(1'b0);
            gen_fields(cur_q, cur_s, cur_l);
            start_batch();
            if (cur_mask != '0) drain(int'($urandom_range(0, 2)), 1'b0);
        end
`ifdef HIT_DISPATCH_STATS_EN
        check("stat_batches_total", stat_batches, exp_batches);
        check("stat_hits_total", stat_hits, exp_hits);
`endif

        // Reset mid-SEND with a stalled hit.
        cur_mask = NL'(3); gen_fields(cur_q, cur_s, cur_l);
        hit_ready = 1'b0;
        start_batch();
        @(negedge com_clk);
        check("stalled_hit_valid", hit_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_hit_valid", hit_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_hit_last", hit_last, 1'b0);
        exp_q.delete();
        @(negedge com_clk);
        reset_n   = 1'b1;
        hit_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge com_clk);
            check("post_rst_no_hit", hit_valid, 1'b0);
            check("post_rst_ready", batch_ready, 1'b1);
        end
`ifdef HIT_DISPATCH_STATS_EN
        check("post_rst_stat_hits", stat_hits, 32'd0);
        check("post_rst_stat_batches", stat_batches, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
